adder_tree_pipe: RTL and testbench

Parametrised, pipelined N-input adder. Successor to the team's fixed 4-input registered adder.
- Sums NUM_IN operands of WIDTH bits through a registered binary tree, with one tree level per pipeline stage.
- Uses a valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure.
- Sum is exact (no overflow); signed or unsigned operation is selected by parameter.

---
 rtl/adder_tree_pkg.sv | 15 +
 rtl/adder_tree_stage.sv | 47 ++++
 rtl/adder_tree_pipe.sv | 75 +++++++
 tb/tb_adder_tree_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package adder_tree_pkg;

    localparam int CNT_W = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: pairwise sums plus a valid bit.
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int N_PAIRS = 2,
    parameter int SIGNED  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           advance,
    input  logic                           in_valid,
    input  logic [2*N_PAIRS*IN_W-1:0]      in_data,
    output logic                           out_valid,
    output logic [N_PAIRS*(IN_W+1)-1:0]    out_data
);

    localparam int OUT_W = IN_W + 1;

    logic [N_PAIRS*OUT_W-1:0] sum;

    function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] a);
        return {(SIGNED != 0) && a[IN_W-1], a};
    endfunction

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_PAIRS; i++) begin
            sum[i*OUT_W +: OUT_W] = ext(in_data[(2*i)*IN_W +: IN_W])
                                  + ext(in_data[(2*i+1)*IN_W +: IN_W]);
        end
    end

    // Bubbles advance the valid bit but leave the data register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= sum;
            end
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_IN-operand adder, one tree level per stage, valid/ready on both sides.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 4,
    parameter  int SIGNED = 0,
    localparam int LVL    = clog2(NUM_IN),
    localparam int OW     = WIDTH + LVL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OW-1:0]           out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        out_count
);

    if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("adder_tree_pipe: NUM_IN must be a power of two >= 2");
    end

    logic advance;

    // A single global stall keeps every level in lockstep.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int IW = WIDTH + k - 1;
        localparam int NP = NUM_IN >> k;

        logic [2*NP*IW-1:0]  d_in;
        logic                v_in;
        logic [NP*(IW+1)-1:0] q;
        logic                v;

        if (k == 1) begin : g_first
            assign d_in = in_data;
            assign v_in = in_valid;
        end else begin : g_next
            assign d_in = g_lvl[k-1].q;
            assign v_in = g_lvl[k-1].v;
        end

        adder_tree_stage #(
            .IN_W    (IW),
            .N_PAIRS (NP),
            .SIGNED  (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (v_in),
            .in_data   (d_in),
            .out_valid (v),
            .out_data  (q)
        );
    end

    assign out_data  = g_lvl[LVL].q;
    assign out_valid = g_lvl[LVL].v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (out_valid && out_ready) begin
            out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench: unsigned 4x16, signed 4x16 and unsigned 8x8 instances.
module tb_adder_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] in_data2 = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_ready2 = 1'b1;

    logic        in_ready0, out_valid0;
    logic [17:0] out_data0;
    logic [15:0] out_count0;
    logic        in_ready1, out_valid1;
    logic [17:0] out_data1;
    logic [15:0] out_count1;
    logic        in_ready2, out_valid2;
    logic [10:0] out_data2;
    logic [15:0] out_count2;

    always #5 clk = ~clk;

    adder_tree_pipe #(.WIDTH(16), .NUM_IN(4), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_count(out_count0)
    );

    adder_tree_pipe #(.WIDTH(16), .NUM_IN(4), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_count(out_count1)
    );

    adder_tree_pipe #(.WIDTH(8), .NUM_IN(8), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_count(out_count2)
    );

    int checks = 0;
    int failures = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [10:0] q2[$];
    logic [15:0] cnt0 = '0;
    logic [15:0] cnt1 = '0;
    logic [15:0] cnt2 = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference sums with plain integer arithmetic.
    function automatic logic [17:0] ref_u(input logic [63:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += longint'(d[i*16 +: 16]);
        return s[17:0];
    endfunction

    function automatic logic [17:0] ref_s(input logic [63:0] d);
        longint s;
        logic signed [15:0] t;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            t = d[i*16 +: 16];
            s += longint'(t);
        end
        return s[17:0];
    endfunction

    function automatic logic [10:0] ref8(input logic [63:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < 8; i++) s += longint'(d[i*8 +: 8]);
        return s[10:0];
    endfunction

    // Monitor: compares outputs against queue heads, records accepted inputs.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count0", {16'd0, out_count0}, {16'd0, cnt0});
            check("count1", {16'd0, out_count1}, {16'd0, cnt1});
            check("count2", {16'd0, out_count2}, {16'd0, cnt2});
            check("in_ready0", {31'd0, in_ready0}, {31'd0, !(out_valid0 && !out_ready)});
            check("in_ready1", {31'd0, in_ready1}, {31'd0, !(out_valid1 && !out_ready)});
            check("in_ready2", {31'd0, in_ready2}, 32'd1);
            if (out_valid0) begin
                if (q0.size() == 0) flag("unexpected0");
                else begin
                    check("data0", {14'd0, out_data0}, {14'd0, q0[0]});
                    if (out_ready) begin
                        void'(q0.pop_front());
                        cnt0++;
                    end
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) flag("unexpected1");
                else begin
                    check("data1", {14'd0, out_data1}, {14'd0, q1[0]});
                    if (out_ready) begin
                        void'(q1.pop_front());
                        cnt1++;
                    end
                end
            end
            if (out_valid2) begin
                if (q2.size() == 0) flag("unexpected2");
                else begin
                    check("data2", {21'd0, out_data2}, {21'd0, q2[0]});
                    if (out_ready2) begin
                        void'(q2.pop_front());
                        cnt2++;
                    end
                end
            end
            if (in_valid && in_ready0) begin
                q0.push_back(ref_u(in_data));
                q1.push_back(ref_s(in_data));
            end
            if (in_valid && in_ready2) q2.push_back(ref8(in_data2));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        in_data  = {$urandom, $urandom};
        in_data2 = {$urandom, $urandom};
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size()) != 0; i++) cycle();
        if ((q0.size() + q1.size() + q2.size()) != 0) flag(name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [15:0] base;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_data", {14'd0, out_data0}, 32'd0);
        check("rst_count", {16'd0, out_count0}, 32'd0);
        check("rst_ready", {31'd0, in_ready0}, 32'd1);
        cycle();

        // All-ones operands: latency and maximum unsigned sum.
        in_data  = {4{16'hFFFF}};
        in_data2 = '1;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("lat_e0", {31'd0, out_valid0}, 32'd0);
        cycle();
        check("lat_e1", {31'd0, out_valid0}, 32'd1);
        check("max_u", {14'd0, out_data0}, 32'h3FFFC);
        check("max_s", {14'd0, out_data1}, 32'h3FFFC);
        check("lat8_e1", {31'd0, out_valid2}, 32'd0);
        cycle();
        check("cnt_one", {16'd0, out_count0}, 32'd1);
        check("lat8_e2", {31'd0, out_valid2}, 32'd1);
        check("max8", {21'd0, out_data2}, 32'h7F8);
        drain("drain_max");

        // Signed corner cases, back to back.
        in_data  = {4{16'h8000}};
        in_valid = 1'b1;
        cycle();
        in_data  = {16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF};
        cycle();
        in_valid = 1'b0;
        check("s_min", {14'd0, out_data1}, 32'h20000);
        cycle();
        check("s_mix", {14'd0, out_data1}, 32'h07FFF);
        drain("drain_signed");

        // Back-to-back streaming.
        base = cnt0;
        for (int i = 0; i < 100; i++) begin
            rand_data();
            in_valid = 1'b1;
            check("stream_rdy", {31'd0, in_ready0}, 32'd1);
            cycle();
        end
        in_valid = 1'b0;
        drain("drain_stream");
        check("stream_cnt", {16'd0, out_count0}, {16'd0, base + 16'd100});

        // Backpressure: fill then stall with a held input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_data();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready0;
            @(posedge clk);
            #1;
            if (acc) rand_data();
        end
        check("bp_stall", {31'd0, in_ready0}, 32'd0);
        check("bp_valid", {31'd0, out_valid0}, 32'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready0;
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_data();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_bp");

        // Alternating out_ready with continuous input.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
            if (acc) rand_data();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_toggle");

        // Reset with two sets in flight.
        rand_data();
        in_valid = 1'b1;
        cycle();
        rand_data();
        cycle();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
        check("mid_rst_data", {14'd0, out_data0}, 32'd0);
        check("mid_rst_count", {16'd0, out_count0}, 32'd0);
        check("mid_rst_valid2", {31'd0, out_valid2}, 32'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        cnt0 = '0;
        cnt1 = '0;
        cnt2 = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        repeat (6) cycle();
        check("post_rst_count", {16'd0, out_count0}, 32'd0);

        // Counter wrap after 65536 transfers.
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            rand_data();
            cycle();
        end
        in_valid = 1'b0;
        drain("drain_wrap");
        check("wrap_cnt", {16'd0, out_count0}, 32'd0);
        check("wrap_cnt2", {16'd0, out_count2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
